uart_rx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_frame.sv | 151 +++++++++++++++
 tb/tb_uart_rx_frame.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state
// encoding, oversampling rate and the baud divisor helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Clocks per oversample tick, never below 1.
    function automatic int baud_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks,
// with a synchronous restart to align ticks to a start edge.
module uart_baud_tick #(
    parameter int DIV = 14
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // Free-running divider, cleared on restart or terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(DIV - 1)) && !restart;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority,
// optional parity, 1/2 stop bits, one-entry holding register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 27000000,
    parameter int BAUDRATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [8:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = baud_div(CLOCK_FREQ, BAUDRATE);

    logic        rx_s1, rx_s2, rx_prev;
    logic [1:0]  sync_ok;
    logic        armed;
    logic        tick, start_edge, maj;
    uart_state_t state;
    logic [3:0]  s;
    logic        smp7, smp8;
    logic [3:0]  bitcnt;
    logic        stopcnt;
    logic [8:0]  shreg, word;
    logic        perr, ferr, ferr_final, par_calc;
    logic        last_stop, frame_done, accept, can_load;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (start_edge),
        .tick    (tick)
    );

    assign start_edge = (state == ST_IDLE) && armed && rx_prev && !rx_s2;
    assign maj        = (smp7 & smp8) | (smp7 & rx_s2) | (smp8 & rx_s2);
    assign word       = shreg >> (9 - DATA_BITS);
    assign par_calc   = (PARITY == PAR_ODD) ? ~^word : ^word;
    assign last_stop  = (stopcnt == 1'(STOP_BITS - 1));
    assign ferr_final = ferr | ~maj;
    assign frame_done = tick && (state == ST_STOP) && (s == 4'd9) && last_stop;
    assign accept     = data_valid && data_ready;
    assign can_load   = !data_valid || accept;
    assign busy       = (state != ST_IDLE);

    // Synchronise rx; arm only once the real pin has been seen high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            sync_ok <= {sync_ok[0], 1'b1};
            armed   <= armed | (sync_ok[1] & rx_s2);
        end
    end

    // Frame state machine, advanced on oversample ticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            s       <= 4'd0;
            smp7    <= 1'b1;
            smp8    <= 1'b1;
            bitcnt  <= 4'd0;
            stopcnt <= 1'b0;
            shreg   <= 9'd0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start_edge) begin
                state   <= ST_START;
                s       <= 4'd0;
                bitcnt  <= 4'd0;
                stopcnt <= 1'b0;
                shreg   <= 9'd0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
            end
        end else if (tick) begin
            s <= s + 4'd1;
            if (s == 4'd7) smp7 <= rx_s2;
            if (s == 4'd8) smp8 <= rx_s2;
            case (state)
                ST_START: begin
                    if (s == 4'd9 && maj) state <= ST_IDLE;
                    else if (s == 4'd15) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (s == 4'd9) shreg <= {maj, shreg[8:1]};
                    if (s == 4'd15) begin
                        if (bitcnt == 4'(DATA_BITS - 1))
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        else
                            bitcnt <= bitcnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (s == 4'd9) perr <= (maj != par_calc);
                    if (s == 4'd15) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (s == 4'd9) begin
                        ferr <= ferr_final;
                        if (last_stop) state <= ST_IDLE;
                    end
                    if (s == 4'd15) stopcnt <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register with handshake and overrun pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= 9'd0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= frame_done && !can_load;
            if (frame_done && can_load) begin
                data_out   <= word;
                parity_err <= perr;
                frame_err  <= ferr_final;
                data_valid <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: table of frames for 8N1, 7E2 and 9O1
// receivers plus overrun, glitch and mid-frame reset sequences.
module tb_uart_rx_frame;

    localparam int BIT = 224;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    typedef struct {
        int         cfg;
        logic [8:0] d;
        bit         flip;
        bit         stopl;
        int         gbit;
        logic [8:0] ed;
        bit         epe;
        bit         efe;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       line  = 1'b1;
    int         tgt   = 0;
    logic       rx0, rx1, rx2;
    logic       rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
    logic [8:0] dout0, dout1, dout2;
    logic       dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2;
    logic       ov0, ov1, ov2, bz0, bz1, bz2;
    logic [8:0] m_dout;
    logic       m_dv, m_rdy, m_pe, m_fe, m_bz;

    word_t q[$];
    word_t w;
    vec_t  vt[11];
    int    total = 0;
    int    bad   = 0;
    int    ov8   = 0;

    always #5 clock = ~clock;

    assign rx0 = (tgt == 0) ? line : 1'b1;
    assign rx1 = (tgt == 1) ? line : 1'b1;
    assign rx2 = (tgt == 2) ? line : 1'b1;

    uart_rx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8n1 (
        .clock(clock), .reset(reset), .rx(rx0), .data_out(dout0),
        .data_valid(dv0), .data_ready(rdy0), .parity_err(pe0),
        .frame_err(fe0), .overrun(ov0), .busy(bz0)
    );

    uart_rx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7e2 (
        .clock(clock), .reset(reset), .rx(rx1), .data_out(dout1),
        .data_valid(dv1), .data_ready(rdy1), .parity_err(pe1),
        .frame_err(fe1), .overrun(ov1), .busy(bz1)
    );

    uart_rx_frame #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) dut9o1 (
        .clock(clock), .reset(reset), .rx(rx2), .data_out(dout2),
        .data_valid(dv2), .data_ready(rdy2), .parity_err(pe2),
        .frame_err(fe2), .overrun(ov2), .busy(bz2)
    );

    // Route the currently targeted receiver to the checker.
    always_comb begin
        m_dout = dout0; m_dv = dv0; m_rdy = rdy0;
        m_pe = pe0; m_fe = fe0; m_bz = bz0;
        case (tgt)
            1: begin
                m_dout = dout1; m_dv = dv1; m_rdy = rdy1;
                m_pe = pe1; m_fe = fe1; m_bz = bz1;
            end
            2: begin
                m_dout = dout2; m_dv = dv2; m_rdy = rdy2;
                m_pe = pe2; m_fe = fe2; m_bz = bz2;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word is popped and compared.
    always @(negedge clock) begin
        if (!reset) begin
            if (ov0) ov8++;
            if (m_dv && m_rdy) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word got=%h pe=%b fe=%b",
                             m_dout, m_pe, m_fe);
                end else begin
                    w = q.pop_front();
                    if ({m_dout, m_pe, m_fe} !== {w.d, w.pe, w.fe}) begin
                        bad++;
                        $display("FAIL word got=%h/%b/%b want=%h/%b/%b",
                                 m_dout, m_pe, m_fe, w.d, w.pe, w.fe);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [8:0] d, input bit pe, input bit fe);
        word_t x;
        x.d = d; x.pe = pe; x.fe = fe;
        q.push_back(x);
    endtask

    // Drive one frame; gbit >= 0 puts a 1-tick glitch at the
    // middle sample of that data bit.
    task automatic send(input int cfg, input logic [8:0] d, input bit flip,
                        input bit stopl, input int gbit);
        int nb, par, ns, n;
        logic [15:0] fr;
        logic p;
        nb  = (cfg == 0) ? 8 : (cfg == 1) ? 7 : 9;
        par = (cfg == 0) ? 0 : (cfg == 1) ? 2 : 1;
        ns  = (cfg == 1) ? 2 : 1;
        fr  = '1;
        fr[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            fr[1+i] = d[i];
            p = p ^ d[i];
        end
        n = 1 + nb;
        if (par != 0) begin
            if (par == 1) p = ~p;
            if (flip) p = ~p;
            fr[n] = p;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            fr[n] = (stopl && i == ns - 1) ? 1'b0 : 1'b1;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            line = fr[i];
            if (gbit >= 0 && i == gbit + 1) begin
                step(120);
                line = ~fr[i];
                step(14);
                line = fr[i];
                step(90);
            end else begin
                step(BIT);
            end
        end
        line = 1'b1;
    endtask

    initial begin
        vt[0]  = '{0, 9'h0A5, 0, 0, -1, 9'h0A5, 0, 0};
        vt[1]  = '{0, 9'h000, 0, 1, -1, 9'h000, 0, 1};
        vt[2]  = '{0, 9'h0FF, 0, 0, -1, 9'h0FF, 0, 0};
        vt[3]  = '{0, 9'h05A, 0, 0,  1, 9'h05A, 0, 0};
        vt[4]  = '{1, 9'h041, 0, 0, -1, 9'h041, 0, 0};
        vt[5]  = '{1, 9'h041, 1, 0, -1, 9'h041, 1, 0};
        vt[6]  = '{1, 9'h02A, 0, 1, -1, 9'h02A, 0, 1};
        vt[7]  = '{1, 9'h07F, 0, 0, -1, 9'h07F, 0, 0};
        vt[8]  = '{2, 9'h1FF, 0, 0, -1, 9'h1FF, 0, 0};
        vt[9]  = '{2, 9'h1FF, 0, 1, -1, 9'h1FF, 0, 1};
        vt[10] = '{2, 9'h100, 1, 0, -1, 9'h100, 1, 0};

        step(5);
        chk("reset_outputs", {4'd0, dv0, pe0, fe0, ov0, bz0, 2'b0, dout0[4:0]},
            16'd0);
        chk("reset_data", {7'd0, dout0}, 16'd0);
        reset = 1'b0;
        step(2 * BIT);

        for (int i = 0; i < 11; i++) begin
            tgt = vt[i].cfg;
            step(2);
            push(vt[i].ed, vt[i].epe, vt[i].efe);
            send(vt[i].cfg, vt[i].d, vt[i].flip, vt[i].stopl, vt[i].gbit);
            step(2 * BIT);
            chk($sformatf("pending_%0d", i), 16'(q.size()), 16'd0);
            chk($sformatf("busy_idle_%0d", i), {15'd0, m_bz}, 16'd0);
        end

        tgt = 0;
        step(2);
        ov8 = 0;
        rdy0 = 1'b0;
        push(9'h011, 0, 0);
        send(0, 9'h011, 0, 0, -1);
        send(0, 9'h022, 0, 0, -1);
        step(BIT);
        chk("overrun_pulses", 16'(ov8), 16'd1);
        chk("held_valid", {15'd0, dv0}, 16'd1);
        chk("held_word", {7'd0, dout0}, 16'h011);
        rdy0 = 1'b1;
        step(1);
        chk("valid_drop", {15'd0, dv0}, 16'd0);
        chk("overrun_pending", 16'(q.size()), 16'd0);

        line = 1'b0;
        step(3);
        line = 1'b1;
        step(20);
        chk("glitch_busy", {15'd0, bz0}, 16'd1);
        step(2 * BIT);
        chk("glitch_idle", {15'd0, bz0}, 16'd0);
        chk("glitch_noword", 16'(q.size()), 16'd0);

        line = 1'b0;
        step(BIT);
        line = 1'b0; step(BIT);
        line = 1'b0; step(BIT);
        line = 1'b1; step(BIT);
        line = 1'b1; step(100);
        reset = 1'b1;
        line = 1'b0;
        step(3);
        chk("midreset_flags", {11'd0, dv0, pe0, fe0, ov0, bz0}, 16'd0);
        chk("midreset_data", {7'd0, dout0}, 16'd0);
        reset = 1'b0;
        step(3 * BIT);
        chk("unarmed_busy", {15'd0, bz0}, 16'd0);
        chk("unarmed_noword", {15'd0, dv0}, 16'd0);
        line = 1'b1;
        step(2 * BIT);
        push(9'h03C, 0, 0);
        send(0, 9'h03C, 0, 0, -1);
        step(2 * BIT);
        chk("after_reset_word", 16'(q.size()), 16'd0);
        chk("after_reset_overrun", 16'(ov8), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
